// File: rtl/core_pkg.sv
// core_pkg: shared fetch-stage reset address, FSM state and buffer entry types
package core_pkg;
   localparam int          XLEN             = 32;
   localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;
   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} fetch_state_e;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] insn;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched {pc, insn} pairs with flush
module fetch_buffer
   import core_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  entry_t     din,
   output entry_t     dout,
   output logic [1:0] occ
);
   entry_t mem [2];
   logic   rd_ptr, wr_ptr;
   assign dout = mem[rd_ptr];
   // ring pointers and occupancy; flush empties the buffer like reset
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited imem requests, redirect draining
module fetch_unit
   import core_pkg::*;
#(
   parameter int                DWIDTH   = 32,
   parameter int                AWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_i,
   input  logic [AWIDTH-1:0] target_i,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [AWIDTH-1:0] imem_req_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [DWIDTH-1:0] imem_rsp_data_i,
   output logic              dec_valid_o,
   input  logic              dec_ready_i,
   output logic [AWIDTH-1:0] dec_pc_o,
   output logic [DWIDTH-1:0] dec_insn_o
);
   typedef struct packed {
      logic [AWIDTH-1:0] pc;
      logic [DWIDTH-1:0] insn;
   } entry_t;
   fetch_state_e      state, state_nxt;
   logic [AWIDTH-1:0] pc, rsp_pc, tgt;
   logic [1:0]        outst, outst_nxt, occ;
   logic              live, hs, push, pop, empty;
   entry_t            head, rsp_entry;
   // responses accepted in RUN are in order and contiguous from the last redirect,
   // so their PC is tracked by rsp_pc instead of a queue of request addresses
   assign tgt              = target_i & ~AWIDTH'(3);
   assign empty            = occ == 2'd0;
   assign imem_req_valid_o = live && state == RUN && (3'(outst) + 3'(occ) < 3'd2);
   assign imem_req_addr_o  = pc;
   assign hs               = imem_req_valid_o && imem_req_ready_i;
   assign push             = imem_rsp_valid_i && state == RUN && !redirect_i;
   assign dec_valid_o      = !empty && !redirect_i;
   assign pop              = dec_valid_o && dec_ready_i;
   assign dec_pc_o         = empty ? '0 : head.pc;
   assign dec_insn_o       = empty ? '0 : head.insn;
   assign rsp_entry        = '{pc: rsp_pc, insn: imem_rsp_data_i};
   assign outst_nxt        = outst + 2'(hs) - 2'(imem_rsp_valid_i);
   assign state_nxt        = ((redirect_i || state == DRAIN) && outst_nxt != 2'd0) ? DRAIN : RUN;
   // fetch PC, expected response PC, in-flight credit count and drain FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         live   <= 1'b0;
         state  <= RUN;
         outst  <= 2'd0;
         pc     <= BASEADDR;
         rsp_pc <= BASEADDR;
      end else begin
         live   <= 1'b1;
         state  <= state_nxt;
         outst  <= outst_nxt;
         pc     <= redirect_i ? tgt : hs ? pc + AWIDTH'(4) : pc;
         rsp_pc <= redirect_i ? tgt : push ? rsp_pc + AWIDTH'(4) : rsp_pc;
      end
   end
   fetch_buffer #(.entry_t(entry_t)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_i),
      .push  (push),
      .pop   (pop),
      .din   (rsp_entry),
      .dout  (head),
      .occ   (occ)
   );
   a_rsp_needs_credit : assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid_i && outst == 2'd0));
   a_credit_cap       : assert property (@(posedge clk) disable iff (!rst_n) outst <= 2'd2);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit requests, decode, redirect and reset
module tb_fetch_unit;
   import core_pkg::*;
   localparam logic [31:0] BASE = 32'h0100_0000;
   logic        clk = 0, rst_n = 0, redirect = 0, mem_ready = 1, rsp_valid = 0, dec_ready = 1;
   logic [31:0] target = 0, rsp_data = 0, req_addr, dec_pc, dec_insn;
   logic        req_valid, dec_valid;
   logic        lat2 = 0, p0v = 0, p1v = 0;
   logic [31:0] p0a = 0, p1a = 0, exp_pc = BASE;
   int          total = 0, bad = 0;
   always #5 clk = ~clk;
   fetch_unit dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .redirect_i       (redirect),
      .target_i         (target),
      .imem_req_valid_o (req_valid),
      .imem_req_ready_i (mem_ready),
      .imem_req_addr_o  (req_addr),
      .imem_rsp_valid_i (rsp_valid),
      .imem_rsp_data_i  (rsp_data),
      .dec_valid_o      (dec_valid),
      .dec_ready_i      (dec_ready),
      .dec_pc_o         (dec_pc),
      .dec_insn_o       (dec_insn)
   );
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic smp();
      @(negedge clk);
   endtask
   // memory: accepts when mem_ready, answers in order after 1 or 2 cycles
   always @(negedge clk) begin
      rsp_valid = rst_n && (lat2 ? p1v : p0v);
      rsp_data  = word_at(lat2 ? p1a : p0a);
      p1v = rst_n && p0v;
      p1a = p0a;
      p0v = rst_n && req_valid && mem_ready;
      p0a = req_addr;
   end
   // decode side: every accepted instruction must be the next expected pc
   always @(negedge clk) begin
      if (rst_n && dec_valid && dec_ready) begin
         chk("dec_pc", dec_pc, exp_pc);
         chk("dec_insn", dec_insn, word_at(exp_pc));
         exp_pc = exp_pc + 32'd4;
      end
   end
   initial begin
      cyc(); cyc(); smp();
      chk("rst_req_valid", req_valid, 0);
      chk("rst_dec_valid", dec_valid, 0);
      chk("rst_dec_pc", dec_pc, 0);
      chk("rst_dec_insn", dec_insn, 0);
      chk("rst_req_addr", req_addr, BASE);
      cyc(); rst_n = 1; smp();
      chk("release_req_valid", req_valid, 0);
      cyc(); smp();
      chk("c1_req_valid", req_valid, 1);
      chk("c1_req_addr", req_addr, BASE);
      chk("c1_dec_valid", dec_valid, 0);
      cyc(); smp();
      chk("c2_req_valid", req_valid, 1);
      chk("c2_req_addr", req_addr, BASE + 32'd4);
      chk("c2_dec_valid", dec_valid, 0);
      cyc(); smp();
      chk("c3_dec_valid", dec_valid, 1);
      chk("c3_dec_pc", dec_pc, BASE);
      chk("c3_dec_insn", dec_insn, word_at(BASE));
      chk("c3_req_valid", req_valid, 0);
      repeat (15) cyc();
      cyc(); dec_ready = 0;
      repeat (9) cyc();
      smp();
      chk("stall_occ", dut.u_buf.occ, 2);
      chk("stall_req_valid", req_valid, 0);
      chk("stall_dec_valid", dec_valid, 1);
      cyc(); dec_ready = 1;
      repeat (20) cyc();
      cyc(); rst_n = 0; lat2 = 1; exp_pc = BASE;
      cyc(); smp();
      chk("midrst_req_valid", req_valid, 0);
      chk("midrst_dec_valid", dec_valid, 0);
      chk("midrst_dec_pc", dec_pc, 0);
      chk("midrst_dec_insn", dec_insn, 0);
      cyc(); rst_n = 1;
      cyc(); smp();
      chk("l2c1_req_addr", req_addr, BASE);
      chk("l2c1_req_valid", req_valid, 1);
      cyc(); smp();
      chk("l2c2_req_addr", req_addr, BASE + 32'd4);
      cyc(); redirect = 1; target = 32'h0100_0100; exp_pc = 32'h0100_0100; smp();
      chk("l2c3_req_valid", req_valid, 0);
      chk("l2c3_dec_valid", dec_valid, 0);
      cyc(); redirect = 0; smp();
      chk("drain_state", dut.state, DRAIN);
      chk("drain_req_valid", req_valid, 0);
      cyc(); smp();
      chk("post_drain_state", dut.state, RUN);
      chk("post_drain_req_valid", req_valid, 1);
      chk("post_drain_req_addr", req_addr, 32'h0100_0100);
      cyc(); smp();
      chk("l2c6_req_addr", req_addr, 32'h0100_0104);
      cyc(); redirect = 1; target = 32'h0100_0280; smp();
      chk("l2c7_req_valid", req_valid, 0);
      cyc(); target = 32'h0100_0300; exp_pc = 32'h0100_0300; smp();
      chk("redir2_state", dut.state, DRAIN);
      chk("redir2_req_valid", req_valid, 0);
      chk("redir2_dec_valid", dec_valid, 0);
      cyc(); redirect = 0; mem_ready = 0; smp();
      chk("redir2_next_state", dut.state, RUN);
      chk("redir2_next_valid", req_valid, 1);
      chk("redir2_next_addr", req_addr, 32'h0100_0300);
      cyc(); redirect = 1; target = 32'h0100_0202; exp_pc = 32'h0100_0200; smp();
      cyc(); redirect = 0; mem_ready = 1; smp();
      chk("align_state", dut.state, RUN);
      chk("align_req_valid", req_valid, 1);
      chk("align_req_addr", req_addr, 32'h0100_0200);
      repeat (30) cyc();
      cyc(); mem_ready = 0;
      repeat (4) cyc();
      cyc(); redirect = 1; target = 32'hFFFF_FFFE; exp_pc = 32'hFFFF_FFFC; smp();
      cyc(); redirect = 0; mem_ready = 1; smp();
      chk("wrap_req_valid", req_valid, 1);
      chk("wrap_req_addr", req_addr, 32'hFFFF_FFFC);
      cyc(); smp();
      chk("wrapped_req_valid", req_valid, 1);
      chk("wrapped_req_addr", req_addr, 32'h0000_0000);
      repeat (20) cyc();
      chk("wrap_decoded", exp_pc > 32'h0000_0008 && exp_pc < 32'h0000_0100, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
